ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage of the five-stage pipeline. It consumes the operands and funct3 held by the ID/EX register and computes one of the eight M-extension results over multiple cycles. While it works it holds the pipeline with a stall request. Its result is muxed with the ALU output ahead of the EX/MEM register.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (branch/jump redirect); aborts any operation in progress.
- start  in  1  EX holds a valid M-extension instruction.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand (post-forwarding).
- b  in  32  rs2 operand (post-forwarding).
- busy  out  1  stall request to the hazard unit; holds PC, IF/ID and ID/EX.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  32  registered result; holds its value until the next completion.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - latch op, |a|, |b| (signedness per op; MULHSU: a signed, b unsigned; unsigned ops pass raw) and the result sign.
  - load iteration counter = 0.
  - go to CALC, or directly to DONE for a special case.
- Special cases, resolved in the IDLE cycle:
  - DIV/DIVU with b=0: quotient 0xFFFFFFFF.
  - REM/REMU with b=0: remainder = a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, REM result 0.
  - The value is written to result at the IDLE->DONE edge.
- CALC, multiply: radix-2 shift-add over 32 iterations into a 64-bit accumulator.
- CALC, divide: restoring shift-subtract over 32 iterations, producing 32-bit quotient and remainder.
- CALC: counter increments each cycle. When counter reaches 31, apply sign fix-up, select the result and go to DONE.
- Sign fix-up:
  - product negated (64-bit two's complement) if signs differ.
  - quotient negated if signs differ.
  - remainder takes the sign of the dividend.
- Result select:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: done=1 and busy=0, so the pipeline advances at this edge. Next state is always IDLE.
- busy = (IDLE & start & ~flush) | CALC. Combinational, so the stall takes effect in the same cycle the instruction enters EX.
- start is ignored outside IDLE. Operands are latched, so a, b, op changes during CALC have no effect.
- flush in any state: next state IDLE, no done pulse, result unchanged. flush with start in IDLE: flush wins, busy=0.
- rst: state IDLE, counter 0, result 0, done 0; busy=0 while start=0. Reset mid-CALC discards the operation.

## Timing
- Start accepted at edge of cycle T (IDLE).
- Normal op: CALC occupies T+1..T+32; DONE at T+33 with done=1 and result valid. busy high T..T+32 (33 cycles).
- Special case: DONE at T+1; busy high only in T.
- Back-to-back M ops: the next start is seen in IDLE at T+34, one cycle after DONE. No lost or duplicated ops.
- result is registered, with no combinational path from a/b to result. busy depends combinationally only on state, start, flush.

## Test plan
- Reset: rst=1 two cycles with start=1 -> result=0, done=0, FSM in IDLE; after release, start seen as a new op.
- MUL/MULH/MULHSU/MULHU:
  - a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001.
  - done at T+33; busy high exactly 33 cycles.
- DIV/REM/DIVU/REMU:
  - a=0xFFFFFFF9 (-7), b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
  - DIVU 0x7FFFFFFC, REMU 1.
- Special cases:
  - DIV by 0 -> 0xFFFFFFFF; REMU 5 by 0 -> 5.
  - DIV 0x80000000 by -1 -> 0x80000000; REM -> 0.
  - Each with done at T+1.
- Flush mid-CALC at T+10 -> busy drops at T+11, no done, result keeps its previous value; a new MUL 3*4 then yields 12.
- Back-to-back DIVU 100/7 then REMU 100/7 -> results 14 then 2, exactly two done pulses, operand changes during CALC ignored.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// One shared 64-bit accumulator serves both the shift-add multiply (hi=partial
// sum, lo=multiplier) and the restoring divide (hi=remainder, lo=dividend/quotient).
//
// state | meaning
// IDLE  | waiting for start; special cases resolved here
// CALC  | 32 iterations of shift-add or shift-subtract
// DONE  | result valid, done pulse, pipeline released
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic [31:0] opnd_q;
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        neg_q;
    logic        rem_neg_q;
    logic        load;
    logic        step;

    logic        a_signed, b_signed, a_sgn, b_sgn;
    logic [31:0] a_mag, b_mag;
    logic        div_by_zero, div_ovf, special;
    logic [31:0] special_val;

    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_diff;
    logic [63:0] acc_step;
    logic [63:0] product;
    logic [31:0] fix_res;

    // Operand decode: magnitudes, signs and the special cases seen in IDLE
    always_comb begin
        a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_sgn       = a_signed & a[31];
        b_sgn       = b_signed & b[31];
        a_mag       = a_sgn ? (~a + 32'd1) : a;
        b_mag       = b_sgn ? (~b + 32'd1) : b;
        div_by_zero = op[2] && (b == 32'd0);
        div_ovf     = ((op == 3'b100) || (op == 3'b110)) &&
                      (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        special     = div_by_zero || div_ovf;
        if (op[1])
            special_val = div_by_zero ? a : 32'd0;
        else
            special_val = div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    end

    // One iteration of multiply or divide, plus sign fix-up and result select
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!op_q[2])
            acc_step = {mul_sum, acc[31:1]};
        else if (!div_diff[32])
            acc_step = {div_diff[31:0], acc[30:0], 1'b1};
        else
            acc_step = {div_shift[31:0], acc[30:0], 1'b0};
        product = neg_q ? (~acc_step + 64'd1) : acc_step;
        case (op_q)
            3'b000:          fix_res = product[31:0];
            3'b001, 3'b010,
            3'b011:          fix_res = product[63:32];
            3'b100, 3'b101:  fix_res = neg_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
            default:         fix_res = rem_neg_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs; flush always returns to IDLE
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    busy       = 1'b1;
                    load       = 1'b1;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == 5'd31)
                        state_next = DONE;
                end
            end
            DONE: begin
                done       = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= 3'd0;
            opnd_q    <= 32'd0;
            acc       <= 64'd0;
            cnt       <= 5'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result    <= 32'd0;
        end else if (load) begin
            op_q      <= op;
            opnd_q    <= op[2] ? b_mag : a_mag;
            acc       <= {32'd0, op[2] ? a_mag : b_mag};
            cnt       <= 5'd0;
            neg_q     <= a_sgn ^ b_sgn;
            rem_neg_q <= a_sgn;
            if (special)
                result <= special_val;
        end else if (step) begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
                result <= fix_res;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and randomized checks of ex_muldiv against an
// arithmetic reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, flush, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    int          done_pulses = 0;
    logic [31:0] last_exp = 32'd0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        int si, sj;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        si = $signed(x);
        sj = $signed(y);
        p  = 64'd0;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return si / sj;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return si % sj;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Called just after a falling edge with the unit idle; returns in the cycle after done.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] e;
        int exp_lat, lat, busy_n;
        e = model(o, x, y);
        exp_lat = ((o[2] && y == 0) ||
                   ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
        op = o; a = x; b = y; start = 1'b1;
        #1 check("busy_on_start", 32'(busy), 32'd1);
        busy_n = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
        check($sformatf("latency op%0d", o), 32'(lat), 32'(exp_lat));
        if (lat != 0) begin
            check("busy_cycles", 32'(busy_n), 32'(exp_lat));
            check("busy_at_done", 32'(busy), 32'd0);
            check($sformatf("result op%0d %h %h", o, x, y), result, e);
            last_exp = e;
            @(negedge clk);
            check("done_width", 32'(done), 32'd0);
        end
    endtask

    initial begin
        int p;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        rst = 1'b1; flush = 1'b0; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        repeat (2) begin
            @(negedge clk);
            check("rst_result", result, 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        do_op(3'd0, 32'd3, 32'd4);

        do_op(3'd0, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd3, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd7, 32'hFFFF_FFF9, 32'd2);

        do_op(3'd4, 32'd123, 32'd0);
        do_op(3'd7, 32'd5, 32'd0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in the middle of a multiply
        op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        p = done_pulses;
        repeat (40) @(negedge clk);
        #1;
        check("flush_no_done", 32'(done_pulses - p), 32'd0);
        check("flush_result_kept", result, last_exp);
        do_op(3'd0, 32'd3, 32'd4);

        // Back-to-back ops with operand churn during CALC
        #1 p = done_pulses;
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);
        #1;
        check("b2b_done_count", 32'(done_pulses - p), 32'd2);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 15));
                3: rx = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op(ro, rx, ry);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
